// File: rtl/slc3_seq_alu.sv
// ============================================================================
// Module   : slc3_seq_alu
// Brief    : Handshake-driven SLC3 ALU with shifts, registered NZP codes and
//            an optional iterative multiply enabled by SLC3_ALU_MUL_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module slc3_seq_alu #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             imm_sel,
    input  logic [IMM_W-1:0] imm,
    input  logic [WIDTH-1:0] sr1_val,
    input  logic [WIDTH-1:0] sr2_val,
    output logic             busy,
    output logic             done,
    output logic             ill_op,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       nzp
);

    localparam int         c_SH_W   = $clog2(WIDTH);
    localparam logic [2:0] c_OP_MUL = 3'b111;
    localparam logic [2:0] c_NZP_Z  = 3'b010;

    logic [WIDTH-1:0]  w_b;
    logic [c_SH_W-1:0] w_shamt;
    logic [WIDTH-1:0]  w_alu;
    logic [WIDTH-1:0]  r_result;
    logic [2:0]        r_nzp;
    logic              r_done;

    function automatic logic [2:0] f_nzp(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1])    return 3'b100;
        else if (v == '0)  return 3'b010;
        else               return 3'b001;
    endfunction

    assign w_b     = imm_sel ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} : sr2_val;
    assign w_shamt = w_b[c_SH_W-1:0];

    // Single-cycle datapath; MUL falls to zero here and is handled separately
    always_comb begin
        w_alu = '0;
        case (op)
            3'b000:  w_alu = sr1_val;
            3'b001:  w_alu = sr1_val & w_b;
            3'b010:  w_alu = ~sr1_val;
            3'b011:  w_alu = sr1_val + w_b;
            3'b100:  w_alu = sr1_val << w_shamt;
            3'b101:  w_alu = sr1_val >> w_shamt;
            3'b110:  w_alu = WIDTH'($signed(sr1_val) >>> w_shamt);
            default: w_alu = '0;
        endcase
    end

`ifdef SLC3_ALU_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [c_SH_W-1:0] r_count;

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        case (r_state)
            S_IDLE: if (start && op == c_OP_MUL) w_next = S_MULT;
            S_MULT: begin
                busy = 1'b1;
                if (r_count == c_SH_W'(WIDTH-1)) w_next = S_FIN;
            end
            S_FIN: begin
                busy   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_nzp    <= c_NZP_Z;
            r_done   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (op == c_OP_MUL) begin
                            r_acc    <= '0;
                            r_mcand  <= sr1_val;
                            r_mplier <= w_b;
                            r_count  <= '0;
                        end else begin
                            r_result <= w_alu;
                            r_nzp    <= f_nzp(w_alu);
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_MULT: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                end
                S_FIN: begin
                    r_result <= r_acc;
                    r_nzp    <= f_nzp(r_acc);
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ill_op = 1'b0;
`else
    logic r_ill_op;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_result <= '0;
            r_nzp    <= c_NZP_Z;
            r_done   <= 1'b0;
            r_ill_op <= 1'b0;
        end else begin
            r_done   <= start;
            r_ill_op <= start && (op == c_OP_MUL);
            if (start) begin
                r_result <= w_alu;
                r_nzp    <= f_nzp(w_alu);
            end
        end
    end

    assign busy   = 1'b0;
    assign ill_op = r_ill_op;
`endif

    assign done   = r_done;
    assign result = r_result;
    assign nzp    = r_nzp;

endmodule

`default_nettype wire
